// File: rtl/fifo_pkg.sv
// Definitions shared by the single- and dual-clock FIFOs: read-mode constants,
// pointer-width derivation and the registered status-flag bundle.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Address bits needed for a power-of-two depth; pointers carry one extra wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the single-clock FIFO. The FIFO is the slave;
// the block feeding and draining it is the master.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int PTR_WIDTH = ptr_width(DEPTH);

  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sfifo_ram.sv
// FIFO storage: one synchronous write port, one read port that is either
// registered (standard mode) or combinational (first-word-fall-through).
module sfifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = FIFO_STD,
  localparam int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset; stale words are unreachable once the pointers
  // are cleared, and leaving it unreset lets synthesis map it onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  // In FWFT mode the output register is dead logic and is trimmed away.
  assign rdata = (FWFT == FIFO_FWFT) ? mem[raddr] : rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, live
// occupancy, standard or FWFT read mode and overflow/underflow pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = FIFO_STD
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int PTR_WIDTH = ptr_width(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_COUNT   = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_COUNT   = CNT_WIDTH'(AE_THRESH);

  logic [CNT_WIDTH-1:0]  wptr;
  logic [CNT_WIDTH-1:0]  rptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  wptr_nxt;
  logic [CNT_WIDTH-1:0]  rptr_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;
  fifo_flags_t           flags;
  fifo_flags_t           flags_nxt;
  logic [DATA_WIDTH-1:0] rd_data;

  // Acceptance uses the registered full/empty, so a full FIFO never takes a
  // write even when a read is popping in the same cycle.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    wr_ok     = bus.w_en && !flags.full;
    rd_ok     = bus.r_en && !flags.empty;
    wptr_nxt  = wptr + CNT_WIDTH'(wr_ok);
    rptr_nxt  = rptr + CNT_WIDTH'(rd_ok);
    count_nxt = wptr_nxt - rptr_nxt;

    flags_nxt              = FLAGS_RESET;
    flags_nxt.full         = (count_nxt == FULL_COUNT);
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= AF_COUNT);
    flags_nxt.almost_empty = (count_nxt <= AE_COUNT);
    flags_nxt.overflow     = bus.w_en && flags.full;
    flags_nxt.underflow    = bus.r_en && flags.empty;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      flags   <= FLAGS_RESET;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      count_q <= count_nxt;
      flags   <= flags_nxt;
    end
  end

  sfifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !rst),
    .waddr (wptr[PTR_WIDTH-1:0]),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rptr[PTR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.count        = count_q;
  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.overflow     = flags.overflow;
  assign bus.underflow    = flags.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode sync_fifo with identical stimulus and
// compares both every cycle against a queue-based model of the FIFO rules.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_std ();
  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_fwft ();

  sync_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_STD)
  ) u_std (.clk(clk), .rst(rst), .bus(bus_std));

  sync_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_FWFT)
  ) u_fwft (.clk(clk), .rst(rst), .bus(bus_fwft));

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the standard-mode output word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] std_dout = '0;
  bit            m_ovf    = 1'b0;
  bit            m_udf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_side(input string side, input logic [3:0] cnt, input logic f,
                            input logic e, input logic af, input logic ae,
                            input logic ovf, input logic udf);
    int n;
    n = q.size();
    check({side, ".count"},        cnt, n);
    check({side, ".full"},         f,   n == DEPTH);
    check({side, ".empty"},        e,   n == 0);
    check({side, ".almost_full"},  af,  n >= AF);
    check({side, ".almost_empty"}, ae,  n <= AE);
    check({side, ".overflow"},     ovf, m_ovf);
    check({side, ".underflow"},    udf, m_udf);
  endtask

  task automatic check_all();
    check_side("std", bus_std.count, bus_std.full, bus_std.empty, bus_std.almost_full,
               bus_std.almost_empty, bus_std.overflow, bus_std.underflow);
    check_side("fwft", bus_fwft.count, bus_fwft.full, bus_fwft.empty, bus_fwft.almost_full,
               bus_fwft.almost_empty, bus_fwft.overflow, bus_fwft.underflow);
    check("std.data_out", bus_std.data_out, std_dout);
    if (q.size() != 0) check("fwft.data_out", bus_fwft.data_out, q[0]);
  endtask

  // One clock cycle: apply inputs, update the model at the edge, check 1ns later.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit rs = 1'b0);
    int n;
    rst              = rs;
    bus_std.w_en     = w;
    bus_std.r_en     = r;
    bus_std.data_in  = d;
    bus_fwft.w_en    = w;
    bus_fwft.r_en    = r;
    bus_fwft.data_in = d;
    @(posedge clk);
    if (rs) begin
      q.delete();
      std_dout = '0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      n     = q.size();
      m_ovf = w && (n == DEPTH);
      m_udf = r && (n == 0);
      if (r && n > 0)     std_dout = q.pop_front();
      if (w && n < DEPTH) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wp;
    bus_std.w_en  = 1'b0; bus_std.r_en  = 1'b0; bus_std.data_in  = '0;
    bus_fwft.w_en = 1'b0; bus_fwft.r_en = 1'b0; bus_fwft.data_in = '0;

    // Reset held two cycles with a write pending: nothing is stored.
    step(1, 0, 8'h55, 1);
    step(1, 0, 8'h55, 1);
    check("reset.count", bus_std.count, 0);
    check("reset.empty", bus_std.empty, 1);
    check("reset.almost_empty", bus_std.almost_empty, 1);
    check("reset.full", bus_std.full, 0);
    check("reset.data_out", bus_std.data_out, 0);
    step(0, 0, 8'h00);

    // Fill 0x10..0x17, then one write into the full FIFO.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'h10 + 8'(i));
      if (i == 0) check("fill.ae_after_1st", bus_std.almost_empty, 1);
      if (i == 1) check("fill.ae_after_2nd", bus_std.almost_empty, 0);
      if (i == 4) check("fill.af_after_5th", bus_std.almost_full, 0);
      if (i == 5) check("fill.af_after_6th", bus_std.almost_full, 1);
    end
    check("fill.full", bus_std.full, 1);
    check("fill.count", bus_std.count, 8);
    step(1, 0, 8'hEE);
    check("fill.overflow", bus_std.overflow, 1);
    check("fill.count_after_ovf", bus_std.count, 8);

    // Drain: each word appears one cycle after its read; the extra read underflows.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.fwft_head", bus_fwft.data_out, 8'h10 + 8'(i));
      step(0, 1, 8'h00);
      check("drain.std_data", bus_std.data_out, 8'h10 + 8'(i));
    end
    check("drain.empty", bus_std.empty, 1);
    step(0, 1, 8'h00);
    check("drain.underflow", bus_std.underflow, 1);
    check("drain.data_hold", bus_std.data_out, 8'h17);

    // Simultaneous access at count=4, across a pointer wrap.
    for (int i = 0; i < 4; i++) step(1, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) step(1, 1, 8'h30 + 8'(i));
    check("simul.count_mid", bus_std.count, 4);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h60 + 8'(i));
    step(1, 1, 8'hEE);
    check("simul.full_ovf", bus_std.overflow, 1);
    check("simul.full_count", bus_std.count, 7);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00);
    step(1, 1, 8'h77);
    check("simul.empty_udf", bus_std.underflow, 1);
    check("simul.empty_count", bus_std.count, 1);
    check("simul.fwft_head", bus_fwft.data_out, 8'h77);
    step(0, 1, 8'h00);

    // FWFT: a write into an empty FIFO is visible without a read.
    step(1, 0, 8'hA5);
    check("fwft.empty_low", bus_fwft.empty, 0);
    check("fwft.first_word", bus_fwft.data_out, 8'hA5);
    step(0, 1, 8'h00);
    check("fwft.empty_after_read", bus_fwft.empty, 1);

    // Random traffic in phases of different fill pressure, with rare resets.
    wp = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) wp = 25 * int'($urandom_range(1, 3));
      step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
           8'($urandom), $urandom_range(999) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
